// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART transceiver.
// Parity-mode codes, TX/RX state encodings, frame length and parity functions.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Bits per frame: start + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_width, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_width + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Payload is zero-extended to 9 bits, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int parity_mode);
    logic p;
    p = ^data;
    case (parity_mode)
      PARITY_EVEN: return p;
      PARITY_ODD:  return ~p;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Three-flop synchroniser for the asynchronous RX line; flops reset to the idle level 1.
module uart_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[2];

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART transceiver: independent TX and RX FSMs with parity and overrun handling.
// Optional feature macro UART_LOOPBACK_EN adds the loopback port and internal TX->RX mux.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_MODE    = 1,
  parameter int STOP_BITS      = 1,
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_busy,
  output logic                  serial_out,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  data_is_valid,
  input  logic                  rx_ack,
  output logic                  rx_error,
  output logic                  framing_error,
  output logic                  overrun_error
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int BIT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_e             tx_state_q, tx_state_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  serial_out_q, serial_out_d;
  logic                  busy_q, busy_d;

  rx_state_e             rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_par_bad_q, rx_par_bad_d;
  logic                  rx_stop_bad_q, rx_stop_bad_d;
  logic                  rx_prev_q, rx_prev_d;
  logic [DATA_WIDTH-1:0] received_q, received_d;
  logic                  valid_q, valid_d;
  logic                  rx_error_q, rx_error_d;
  logic                  framing_q, framing_d;
  logic                  overrun_q, overrun_d;

  logic rx_src;
  logic rx_s;
  logic stop_bad_now;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? serial_out_q : serial_in;
`else
  assign rx_src = serial_in;
`endif

  uart_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_src),
    .q     (rx_s)
  );

  // TX next state: serial_out_d is the line level for the coming cycle.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_par_d     = tx_par_q;
    serial_out_d = serial_out_q;
    busy_d       = busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (enable) begin
          tx_state_d   = TX_START;
          tx_shift_d   = i_data;
          tx_par_d     = parity_bit(9'(i_data), PARITY_MODE);
          tx_cnt_d     = '0;
          serial_out_d = 1'b0;
          busy_d       = 1'b1;
        end else begin
          serial_out_d = 1'b1;
          busy_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d     = '0;
          tx_bit_d     = '0;
          tx_state_d   = TX_DATA;
          serial_out_d = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d = '0;
            if (PARITY_MODE != PARITY_NONE) begin
              tx_state_d   = TX_PARITY;
              serial_out_d = tx_par_q;
            end else begin
              tx_state_d   = TX_STOP;
              serial_out_d = 1'b1;
            end
          end else begin
            tx_bit_d     = tx_bit_q + BIT_ONE;
            tx_shift_d   = tx_shift_q >> 1;
            serial_out_d = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d     = '0;
          tx_bit_d     = '0;
          tx_state_d   = TX_STOP;
          serial_out_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d   = TX_IDLE;
            busy_d       = 1'b0;
            serial_out_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + BIT_ONE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d   = TX_IDLE;
        tx_cnt_d     = '0;
        serial_out_d = 1'b1;
        busy_d       = 1'b0;
      end
    endcase
  end

  // RX next state: a frame is judged on its final stop sample; errored frames never load.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_par_bad_d  = rx_par_bad_q;
    rx_stop_bad_d = rx_stop_bad_q;
    rx_prev_d     = rx_s;
    received_d    = received_q;
    valid_d       = valid_q & ~rx_ack;
    rx_error_d    = 1'b0;
    framing_d     = 1'b0;
    overrun_d     = 1'b0;
    stop_bad_now  = rx_stop_bad_q | ~rx_s;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s && rx_prev_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (!rx_s) begin
            rx_state_d    = RX_DATA;
            rx_bit_d      = '0;
            rx_par_bad_d  = 1'b0;
            rx_stop_bad_d = 1'b0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_bit_d = '0;
            if (PARITY_MODE != PARITY_NONE) begin
              rx_state_d = RX_PARITY;
            end else begin
              rx_state_d = RX_STOP;
            end
          end else begin
            rx_bit_d = rx_bit_q + BIT_ONE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d     = '0;
          rx_bit_d     = '0;
          rx_par_bad_d = (rx_s != parity_bit(9'(rx_shift_q), PARITY_MODE));
          rx_state_d   = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_bit_q == STOP_LAST) begin
            rx_state_d = RX_IDLE;
            if (rx_par_bad_q || stop_bad_now) begin
              rx_error_d = rx_par_bad_q;
              framing_d  = stop_bad_now;
            end else begin
              received_d = rx_shift_q;
              valid_d    = 1'b1;
              overrun_d  = valid_q & ~rx_ack;
            end
          end else begin
            rx_stop_bad_d = stop_bad_now;
            rx_bit_d      = rx_bit_q + BIT_ONE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // State registers for both directions; reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      serial_out_q  <= 1'b1;
      busy_q        <= 1'b0;
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_bad_q  <= 1'b0;
      rx_stop_bad_q <= 1'b0;
      rx_prev_q     <= 1'b1;
      received_q    <= '0;
      valid_q       <= 1'b0;
      rx_error_q    <= 1'b0;
      framing_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_par_q      <= tx_par_d;
      serial_out_q  <= serial_out_d;
      busy_q        <= busy_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_bad_q  <= rx_par_bad_d;
      rx_stop_bad_q <= rx_stop_bad_d;
      rx_prev_q     <= rx_prev_d;
      received_q    <= received_d;
      valid_q       <= valid_d;
      rx_error_q    <= rx_error_d;
      framing_q     <= framing_d;
      overrun_q     <= overrun_d;
    end
  end

  assign o_busy        = busy_q;
  assign serial_out    = serial_out_q;
  assign received_data = received_q;
  assign data_is_valid = valid_q;
  assign rx_error      = rx_error_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;

endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH, 8, payload bits per frame, legal range 5..9.
  PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
  STOP_BITS, 1, legal values 1 or 2.
  CLOCKS_PER_BIT, 8, clk cycles per bit, even, at least 4.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  sole clock; every flop is clocked on the rising edge.
  reset  input  1  synchronous, active-low reset (0 = reset).
  enable  input  1  transmit request.
  i_data  input  DATA_WIDTH  transmit payload.
  o_busy  output  1  transmitter occupied.
  serial_out  output  1  TX line, idles at 1.
  serial_in  input  1  asynchronous RX line.
  received_data  output  DATA_WIDTH  last received payload.
  data_is_valid  output  1  received_data holds a frame not yet acknowledged.
  rx_ack  input  1  consumer acknowledge.
  rx_error  output  1  parity-error pulse.
  framing_error  output  1  stop-bit-error pulse.
  overrun_error  output  1  unacknowledged frame was overwritten (pulse).
  loopback  input  1  exists only under UART_LOOPBACK_EN.

Function
REQ-003 The transmitter SHALL accept a request when enable=1 and o_busy=0, capture i_data on that edge, and set o_busy=1 on the next cycle; enable while o_busy=1 SHALL be ignored, not queued.
REQ-004 The TX FSM SHALL be IDLE -> START -> DATA -> PARITY -> STOP -> IDLE, with PARITY skipped when PARITY_MODE=0; each bit SHALL last exactly CLOCKS_PER_BIT cycles.
REQ-005 Frame order SHALL be start bit 0, data LSB first, parity (even: XOR of data; odd: its inverse), then STOP_BITS ones; serial_out SHALL go low the cycle after acceptance.
REQ-006 o_busy SHALL fall in the cycle after the last stop-bit cycle, so back-to-back frames SHALL have no extra idle bit.
REQ-007 Changes to i_data after acceptance SHALL NOT affect the frame in flight.
REQ-008 serial_in SHALL pass through a 3-flop synchroniser before any use.
REQ-009 The RX FSM SHALL be IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; it SHALL leave IDLE on a synchronised 1->0 edge.
REQ-010 The RX FSM SHALL sample the line CLOCKS_PER_BIT/2 cycles after the edge; if the sample is 1 the edge is a glitch and the FSM SHALL return to IDLE with no output.
REQ-011 After a valid start sample, the receiver SHALL sample every CLOCKS_PER_BIT cycles; with STOP_BITS=2 both stop bits SHALL be sampled.
REQ-012 On a clean frame, received_data SHALL update and data_is_valid SHALL rise in the cycle after the final stop sample.
REQ-013 In loopback, that cycle SHALL be 5 + CLOCKS_PER_BIT/2 + (F-1)*CLOCKS_PER_BIT cycles after acceptance, where F = 1 + DATA_WIDTH + (PARITY_MODE != 0) + STOP_BITS; with defaults this is cycle 89.
REQ-014 data_is_valid SHALL stay high until the first cycle in which rx_ack=1, then clear on the next edge.
REQ-015 A parity mismatch SHALL pulse rx_error for 1 cycle; a 0 stop sample SHALL pulse framing_error for 1 cycle; an errored frame SHALL NOT update received_data or data_is_valid.
REQ-016 If a clean frame completes while data_is_valid=1 and rx_ack=0, the receiver SHALL overwrite received_data, pulse overrun_error and keep data_is_valid=1.
REQ-017 If rx_ack=1 in the same cycle a clean frame completes, the receiver SHALL load the new data, keep data_is_valid=1 and SHALL NOT flag overrun.
REQ-018 TX and RX SHALL operate fully independently (full duplex).

Reset
REQ-019 While reset=0: serial_out=1, o_busy=0, data_is_valid=0, received_data=0, all error outputs 0, synchroniser flops=1, both FSMs IDLE, counters 0.
REQ-020 Reset asserted mid-frame SHALL abort both directions within one cycle; the partial frame SHALL be discarded with no error pulse.

Configuration
REQ-021 The configuration macro SHALL be UART_LOOPBACK_EN.
REQ-022 With UART_LOOPBACK_EN defined, the loopback port SHALL exist; loopback=1 SHALL feed serial_out to the synchroniser input in place of serial_in, while serial_out keeps driving the pin.
REQ-023 Without UART_LOOPBACK_EN, the loopback port and mux SHALL be absent and serial_in SHALL be the only RX source.

Structure
REQ-024 Package uart_pkg SHALL hold the PARITY_MODE encodings, the TX/RX state encodings and a frame-length constant function.
REQ-025 The synchroniser SHALL be sub-module uart_sync (3 flops, reset value 1).

Verification
REQ-026 Loopback, defaults, enable with i_data=8'hA5 -> data_is_valid rises at cycle 89, received_data=8'hA5, no error pulses.
REQ-027 PARITY_MODE=2, STOP_BITS=2, i_data=8'h00 -> parity bit on serial_out is 1; o_busy stays high for 12*8=96 cycles.
REQ-028 A 2-cycle low glitch on serial_in -> RX returns to IDLE; no data_is_valid and no error pulses.
REQ-029 Inject a frame with a corrupted parity bit, then a frame with a 0 stop bit -> one rx_error pulse, then one framing_error pulse; received_data unchanged.
REQ-030 Two clean frames, 8'h11 then 8'h22, with rx_ack held low -> overrun_error pulses once, received_data=8'h22; repeat with rx_ack=1 in the completion cycle -> no overrun.
REQ-031 Assert reset for 1 cycle mid-DATA -> serial_out=1 and o_busy=0 on the next cycle; no data_is_valid follows.
